// File: rtl/matvec_ntt_mul_pkg.sv
`default_nettype none
// matvec_ntt_mul_pkg -- ML-KEM polynomial types, zeta^(2*BitRev7(k)+1) ROM and mod-q helpers
// Revision: 1.0
package matvec_ntt_mul_pkg;

  localparam int ML_KEM_K     = 2;
  localparam int ML_KEM_Q     = 3329;
  localparam int ML_KEM_LEN_Q = 12;
  localparam int ML_KEM_N     = 256;
  localparam int IW           = (ML_KEM_K > 1) ? $clog2(ML_KEM_K) : 1;
  localparam int unsigned BARRETT_M = (1 << 24) / ML_KEM_Q;

  typedef logic [ML_KEM_LEN_Q-1:0] coeff_t;
  typedef coeff_t [ML_KEM_N-1:0]   poly_t;
  typedef poly_t [ML_KEM_K-1:0]    polyvec_t;
  typedef polyvec_t [ML_KEM_K-1:0] polymat_t;
  typedef coeff_t [127:0]          gamma_tab_t;

  typedef struct packed {
    logic [IW-1:0] i;
    logic [6:0]    k;
    logic          first;
  } tag_t;

  function automatic gamma_tab_t gen_gamma();
    gamma_tab_t  tab;
    logic [6:0]  kk;
    logic [6:0]  br;
    int unsigned ex;
    int unsigned base;
    int unsigned acc;
    int unsigned q;
    tab = '0;
    q   = ML_KEM_Q;
    for (int k = 0; k < 128; k++) begin
      kk   = 7'(k);
      br   = {kk[0], kk[1], kk[2], kk[3], kk[4], kk[5], kk[6]};
      ex   = (32'(br) << 1) | 32'd1;
      base = 32'd17;
      acc  = 32'd1;
      for (int n = 0; n < 8; n++) begin
        if (ex[0]) acc = (acc * base) % q;
        base = (base * base) % q;
        ex   = ex >> 1;
      end
      tab[kk] = coeff_t'(acc);
    end
    return tab;
  endfunction

  localparam gamma_tab_t ML_KEM_GAMMA = gen_gamma();

  // Quotient estimate is at most one short for x < 2^24, so one subtract suffices.
  function automatic coeff_t barrett_reduce(input logic [23:0] x);
    logic [12:0] qe;
    logic [12:0] r;
    qe = 13'(({13'd0, x} * 37'(BARRETT_M)) >> 24);
    r  = x[12:0] - qe * 13'(ML_KEM_Q);
    return (r >= 13'(ML_KEM_Q)) ? coeff_t'(r - 13'(ML_KEM_Q)) : r[11:0];
  endfunction

  function automatic coeff_t mod_add(input coeff_t a, input coeff_t b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 13'(ML_KEM_Q)) ? coeff_t'(s - 13'(ML_KEM_Q)) : s[11:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/matvec_ntt_mul_basemul_pipe.sv
`default_nettype none
// matvec_ntt_mul_basemul_pipe -- 3-stage BaseCaseMultiply: products, reduce + gamma, combine
// Revision: 1.0
module matvec_ntt_mul_basemul_pipe
  import matvec_ntt_mul_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_n_i,
  input  logic   valid_i,
  input  coeff_t a0_i,
  input  coeff_t a1_i,
  input  coeff_t b0_i,
  input  coeff_t b1_i,
  input  coeff_t gamma_i,
  input  tag_t   tag_i,
  output logic   valid_o,
  output coeff_t c0_o,
  output coeff_t c1_o,
  output tag_t   tag_o
);

  logic [23:0] p00_q, p11_q, p01_q, p10_q;
  coeff_t      g1_q;
  tag_t        tag1_q;
  logic        v1_q;

  coeff_t      r00_q, r01_q, r10_q;
  logic [23:0] pg_q;
  tag_t        tag2_q;
  logic        v2_q;

  coeff_t      c0_q, c1_q;
  tag_t        tag3_q;
  logic        v3_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      v2_q <= v1_q;
      v3_q <= v2_q;
    end
  end

  // Data path needs no reset: only the valid chain qualifies it.
  always_ff @(posedge clk_i) begin
    p00_q  <= {12'd0, a0_i} * {12'd0, b0_i};
    p11_q  <= {12'd0, a1_i} * {12'd0, b1_i};
    p01_q  <= {12'd0, a0_i} * {12'd0, b1_i};
    p10_q  <= {12'd0, a1_i} * {12'd0, b0_i};
    g1_q   <= gamma_i;
    tag1_q <= tag_i;

    r00_q  <= barrett_reduce(p00_q);
    r01_q  <= barrett_reduce(p01_q);
    r10_q  <= barrett_reduce(p10_q);
    pg_q   <= {12'd0, barrett_reduce(p11_q)} * {12'd0, g1_q};
    tag2_q <= tag1_q;

    c0_q   <= mod_add(r00_q, barrett_reduce(pg_q));
    c1_q   <= mod_add(r01_q, r10_q);
    tag3_q <= tag2_q;
  end

  assign valid_o = v3_q;
  assign c0_o    = c0_q;
  assign c1_o    = c1_q;
  assign tag_o   = tag3_q;

endmodule
`default_nettype wire

// File: rtl/matvec_ntt_mul.sv
`default_nettype none
// matvec_ntt_mul -- NTT-domain t_hat = A_hat o s_hat (+ e_hat), one coefficient pair per cycle
// Revision: 1.0
module matvec_ntt_mul
  import matvec_ntt_mul_pkg::*;
#(
  parameter int PIPE_DEPTH = 3
) (
  input  logic     clk_i,
  input  logic     rst_n_i,
  input  logic     run_i,
  input  logic     add_e_i,
  input  polymat_t polymat_A_i,
  input  polyvec_t polyvec_s_i,
  input  polyvec_t polyvec_e_i,
  output logic     busy_o,
  output logic     done_o,
  output polyvec_t polyvec_t_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int            DW      = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [IW-1:0] LAST_IJ = IW'(ML_KEM_K - 1);

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] i_q, i_d, j_q, j_d;
  logic [6:0]    k_q, k_d;
  logic [DW-1:0] drn_q, drn_d;
  logic          add_e_q;
  polyvec_t      acc_q;

  logic          last_w;
  logic [7:0]    idx0_w, idx1_w;
  tag_t          tag_w;

  logic          wb_v_w;
  coeff_t        c0_w, c1_w;
  tag_t          wb_tag_w;
  logic [7:0]    widx0_w, widx1_w;
  coeff_t        base0_w, base1_w, sum0_w, sum1_w;

  assign last_w = (i_q == LAST_IJ) && (j_q == LAST_IJ) && (k_q == 7'd127);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    drn_d   = drn_q;
    case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d = S_ISSUE;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
        end
      end
      S_ISSUE: begin
        k_d = k_q + 7'd1;
        if (k_q == 7'd127) begin
          if (j_q == LAST_IJ) begin
            j_d = '0;
            i_d = i_q + IW'(1);
          end else begin
            j_d = j_q + IW'(1);
          end
        end
        if (last_w) begin
          state_d = S_DRAIN;
          drn_d   = '0;
        end
      end
      // One drain cycle per pipeline stage covers the in-flight pairs.
      S_DRAIN: begin
        drn_d = drn_q + DW'(1);
        if (drn_q == DW'(PIPE_DEPTH - 1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign idx0_w = {k_q, 1'b0};
  assign idx1_w = {k_q, 1'b1};
  assign tag_w  = {i_q, k_q, (j_q == '0)};

  matvec_ntt_mul_basemul_pipe u_basemul_pipe (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .valid_i (state_q == S_ISSUE),
    .a0_i    (polymat_A_i[i_q][j_q][idx0_w]),
    .a1_i    (polymat_A_i[i_q][j_q][idx1_w]),
    .b0_i    (polyvec_s_i[j_q][idx0_w]),
    .b1_i    (polyvec_s_i[j_q][idx1_w]),
    .gamma_i (ML_KEM_GAMMA[k_q]),
    .tag_i   (tag_w),
    .valid_o (wb_v_w),
    .c0_o    (c0_w),
    .c1_o    (c1_w),
    .tag_o   (wb_tag_w)
  );

  assign widx0_w = {wb_tag_w.k, 1'b0};
  assign widx1_w = {wb_tag_w.k, 1'b1};

  always_comb begin
    base0_w = acc_q[wb_tag_w.i][widx0_w];
    base1_w = acc_q[wb_tag_w.i][widx1_w];
    if (wb_tag_w.first) begin
      base0_w = add_e_q ? polyvec_e_i[wb_tag_w.i][widx0_w] : '0;
      base1_w = add_e_q ? polyvec_e_i[wb_tag_w.i][widx1_w] : '0;
    end
    sum0_w = mod_add(base0_w, c0_w);
    sum1_w = mod_add(base1_w, c1_w);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      drn_q   <= '0;
      add_e_q <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      drn_q   <= drn_d;
      if ((state_q == S_IDLE) && run_i) begin
        add_e_q <= add_e_i;
        acc_q   <= '0;
      end else if (wb_v_w) begin
        acc_q[wb_tag_w.i][widx0_w] <= sum0_w;
        acc_q[wb_tag_w.i][widx1_w] <= sum1_w;
      end
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign polyvec_t_o = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_matvec_ntt_mul.sv
`default_nettype none
// tb_matvec_ntt_mul -- scoreboard bench: stimulus queues expectations, a monitor checks done_o/busy_o
// Revision: 1.0
module tb_matvec_ntt_mul;
  import matvec_ntt_mul_pkg::*;

  typedef struct {
    polyvec_t t;
    int       cyc;
  } res_t;

  typedef struct {
    int   cyc;
    logic busy;
    logic zero;
  } st_t;

  logic     clk = 1'b0;
  logic     rst_n_i;
  logic     run_i;
  logic     add_e_i;
  polymat_t A;
  polyvec_t s;
  polyvec_t e;
  logic     busy_o;
  logic     done_o;
  polyvec_t polyvec_t_o;

  int     cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     nz;
  longint gam [128];
  res_t   res_q[$];
  st_t    st_q[$];
  res_t   res_cur;
  st_t    st_cur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matvec_ntt_mul #(.PIPE_DEPTH(3)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n_i),
    .run_i       (run_i),
    .add_e_i     (add_e_i),
    .polymat_A_i (A),
    .polyvec_s_i (s),
    .polyvec_e_i (e),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .polyvec_t_o (polyvec_t_o)
  );

  // Reference: FIPS 203 MultiplyNTTs accumulated over j, plain integer arithmetic.
  function automatic polyvec_t ref_model(input polymat_t a, input polyvec_t sv,
                                         input polyvec_t ev, input logic ae);
    polyvec_t r;
    longint   sum [256];
    longint   a0, a1, b0, b1;
    r = '0;
    for (int i = 0; i < ML_KEM_K; i++) begin
      for (int n = 0; n < 256; n++) sum[n] = ae ? longint'(ev[i][n]) : 64'sd0;
      for (int j = 0; j < ML_KEM_K; j++) begin
        for (int k = 0; k < 128; k++) begin
          a0 = longint'(a[i][j][2*k]);
          a1 = longint'(a[i][j][2*k+1]);
          b0 = longint'(sv[j][2*k]);
          b1 = longint'(sv[j][2*k+1]);
          sum[2*k]   += a0 * b0 + ((a1 * b1) % 3329) * gam[k];
          sum[2*k+1] += a0 * b1 + a1 * b0;
        end
      end
      for (int n = 0; n < 256; n++) r[i][n] = coeff_t'(sum[n] % 3329);
    end
    return r;
  endfunction

  function automatic void st_push(input int c, input logic b, input logic z);
    st_t x;
    x.cyc  = c;
    x.busy = b;
    x.zero = z;
    st_q.push_back(x);
  endfunction

  task automatic rand_fill();
    for (int i = 0; i < ML_KEM_K; i++) begin
      for (int n = 0; n < 256; n++) begin
        for (int j = 0; j < ML_KEM_K; j++) A[i][j][n] = coeff_t'($urandom_range(0, 3328));
        s[i][n] = coeff_t'($urandom_range(0, 3328));
        e[i][n] = coeff_t'($urandom_range(0, 3328));
      end
    end
  endtask

  task automatic run_op(input logic ae, input bit expect_res, output int c0);
    res_t r;
    @(negedge clk);
    run_i   = 1'b1;
    add_e_i = ae;
    @(posedge clk);
    #1;
    c0 = cyc;
    if (expect_res) begin
      r.t   = ref_model(A, s, e, ae);
      r.cyc = c0 + 515;
      res_q.push_back(r);
    end
    @(negedge clk);
    run_i = 1'b0;
  endtask

  task automatic wait_done(input int c0, input bit poke_done);
    int g;
    st_push(c0 + 515, 1'b1, 1'b0);
    st_push(c0 + 516, 1'b0, 1'b0);
    st_push(c0 + 520, 1'b0, 1'b0);
    if (poke_done) begin
      while (cyc < c0 + 515) @(negedge clk);
      run_i   = 1'b1;
      add_e_i = ~add_e_i;
      @(negedge clk);
      run_i = 1'b0;
    end
    g = 0;
    while (((res_q.size() != 0) || (st_q.size() != 0)) && (g < 2000)) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) begin
      $display("FAIL wait_bound: scoreboard not drained after %0d cycles, required 0 pending", g);
      $fatal(1, "scoreboard stuck");
    end
  endtask

  // Monitor: sole owner of checks/errors.
  always @(negedge clk) begin
    if ((st_q.size() > 0) && (cyc >= st_q[0].cyc)) begin
      st_cur = st_q.pop_front();
      checks++;
      if ((busy_o !== st_cur.busy) || (cyc != st_cur.cyc)) begin
        errors++;
        $display("FAIL busy_check at cyc %0d (planned %0d): busy_o=%b required %b",
                 cyc, st_cur.cyc, busy_o, st_cur.busy);
      end
      if (st_cur.zero) begin
        nz = 0;
        for (int i = 0; i < ML_KEM_K; i++)
          for (int n = 0; n < 256; n++)
            if (polyvec_t_o[i][n] !== '0) nz++;
        checks++;
        if ((done_o !== 1'b0) || (nz != 0)) begin
          errors++;
          $display("FAIL reset_state at cyc %0d: done_o=%b nonzero_coeffs=%0d required done_o=0 nonzero_coeffs=0",
                   cyc, done_o, nz);
        end
      end
    end
    if (done_o === 1'b1) begin
      checks++;
      if (res_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done at cyc %0d: done_o=1 required 0", cyc);
      end else begin
        res_cur = res_q.pop_front();
        if (cyc != res_cur.cyc) begin
          errors++;
          $display("FAIL done_cycle: done_o at cyc %0d required cyc %0d", cyc, res_cur.cyc);
        end
        for (int i = 0; i < ML_KEM_K; i++) begin
          for (int n = 0; n < 256; n++) begin
            checks++;
            if (polyvec_t_o[i][n] !== res_cur.t[i][n]) begin
              errors++;
              $display("FAIL coeff t[%0d][%0d] at cyc %0d: got %0d required %0d",
                       i, n, cyc, polyvec_t_o[i][n], res_cur.t[i][n]);
            end
          end
        end
      end
    end else if ((res_q.size() > 0) && (cyc > res_q[0].cyc + 4)) begin
      res_cur = res_q.pop_front();
      checks++;
      errors++;
      $display("FAIL done_timeout at cyc %0d: done_o=0 required 1 at cyc %0d", cyc, res_cur.cyc);
    end
  end

  initial begin
    int c0;
    int brv;
    longint g;
    rst_n_i = 1'b0;
    run_i   = 1'b0;
    add_e_i = 1'b0;
    A = '0;
    s = '0;
    e = '0;
    for (int k = 0; k < 128; k++) begin
      brv = 0;
      for (int b = 0; b < 7; b++) if (((k >> b) & 1) != 0) brv |= (1 << (6 - b));
      g = 1;
      for (int x = 0; x < 2 * brv + 1; x++) g = (g * 17) % 3329;
      gam[k] = g;
    end

    repeat (2) @(negedge clk);
    st_push(cyc + 1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst_n_i = 1'b1;

    // Single product lands in t[0][0]
    A[0][0][0] = 12'd1;
    s[0][0]    = 12'd5;
    run_op(1'b0, 1'b1, c0);
    wait_done(c0, 1'b0);

    // a1*b1 path picks up gamma[0]; e present but not added
    A = '0;
    s = '0;
    rand_fill();
    A = '0;
    s = '0;
    A[0][0][1] = 12'd1;
    s[0][1]    = 12'd1;
    run_op(1'b0, 1'b1, c0);
    wait_done(c0, 1'b0);

    // All-maximum operands with e added; run_i in the done cycle must be ignored
    for (int i = 0; i < ML_KEM_K; i++) begin
      for (int n = 0; n < 256; n++) begin
        for (int j = 0; j < ML_KEM_K; j++) A[i][j][n] = 12'd3328;
        s[i][n] = 12'd3328;
        e[i][n] = 12'd3328;
      end
    end
    run_op(1'b1, 1'b1, c0);
    wait_done(c0, 1'b1);

    // Random operands; run 1 also gets a second run_i while busy
    for (int r = 0; r < 4; r++) begin
      rand_fill();
      run_op(logic'($urandom_range(0, 1)), 1'b1, c0);
      if (r == 1) begin
        while (cyc < c0 + 99) @(negedge clk);
        run_i   = 1'b1;
        add_e_i = ~add_e_i;
        st_push(c0 + 100, 1'b1, 1'b0);
        @(negedge clk);
        run_i = 1'b0;
      end
      wait_done(c0, 1'b0);
    end

    // Reset mid-operation aborts with no done_o
    rand_fill();
    run_op(1'b1, 1'b0, c0);
    while (cyc < c0 + 199) @(negedge clk);
    rst_n_i = 1'b0;
    st_push(c0 + 200, 1'b0, 1'b1);
    @(negedge clk);
    rst_n_i = 1'b1;
    repeat (600) @(negedge clk);

    rand_fill();
    run_op(1'b1, 1'b1, c0);
    wait_done(c0, 1'b0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
